sdram_line_fill: RTL and testbench

Burst fill engine that sits directly upstream of the 256x32 SDRAM cache data buffer. It takes a line-fill request from the cache controller and issues a single burst read to the SDRAM controller. It then packs the returned 16-bit halfwords big-endian into 32-bit words and writes them into one buffer port. Completion or timeout is signalled back with a one-cycle acknowledge.

---
 rtl/sdram_fill_pkg.sv | 22 ++
 rtl/sdram_line_fill_if.sv | 40 ++++
 rtl/sdram_hw_packer.sv | 34 +++
 rtl/sdram_line_fill.sv | 125 ++++++++++++
 tb/tb_sdram_line_fill.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_fill_pkg.sv
// Shared types and width helpers for the SDRAM line-fill engine.
package sdram_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

    localparam int LINE_WORDS_DEF = 4;
    localparam int LINE_HW        = 2 * LINE_WORDS_DEF;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdram_line_fill_if.sv
// Fill request, SDRAM burst and buffer write signals of the line-fill engine.
interface sdram_line_fill_if
    import sdram_fill_pkg::*;
#(
    parameter int AW         = 8,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int SA_W       = 25
) ();

    localparam int LINE_W = AW - log2_ceil(LINE_WORDS);

    logic              fill_req;
    logic [LINE_W-1:0] fill_line;
    logic [SA_W-1:0]   fill_addr;
    logic              busy;
    logic              fill_ack;
    logic              fill_err;

    logic              sd_req;
    logic [SA_W-1:0]   sd_addr;
    logic              sd_gnt;
    logic              sd_dv;
    logic [15:0]       sd_dat;

    logic              buf_we;
    logic [AW-1:0]     buf_addr;
    logic [31:0]       buf_dat;

    // master: the fill engine; slave: cache controller, SDRAM controller and buffer.
    modport master (
        input  fill_req, fill_line, fill_addr, sd_gnt, sd_dv, sd_dat,
        output busy, fill_ack, fill_err, sd_req, sd_addr, buf_we, buf_addr, buf_dat
    );

    modport slave (
        output fill_req, fill_line, fill_addr, sd_gnt, sd_dv, sd_dat,
        input  busy, fill_ack, fill_err, sd_req, sd_addr, buf_we, buf_addr, buf_dat
    );

endinterface

// File: rtl/sdram_hw_packer.sv
// Packs big-endian halfword pairs into 32-bit words with a one-cycle valid strobe.
module sdram_hw_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        take,
    input  logic        odd,
    input  logic [15:0] dat,
    output logic [31:0] word,
    output logic        valid
);

    logic [15:0] high;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high  <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= take && odd;
            if (start) begin
                high <= '0;
            end else if (take && !odd) begin
                high <= dat;
            end
            if (take && odd) begin
                word <= {high, dat};
            end
        end
    end

endmodule

// File: rtl/sdram_line_fill.sv
// Line-fill engine: one SDRAM burst per request, packed into buffer words, acked once.
module sdram_line_fill
    import sdram_fill_pkg::*;
#(
    parameter int AW         = 8,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int SA_W       = 25,
    parameter int TIMEOUT    = 64
) (
    input  logic               clock,
    input  logic               reset,
    sdram_line_fill_if.master  bus
);

    localparam int LW_W   = log2_ceil(LINE_WORDS);
    localparam int LINE_W = AW - LW_W;
    localparam int HW_N   = 2 * LINE_WORDS;
    localparam int HW_W   = log2_ceil(HW_N);
    localparam int OFF_W  = log2_ceil(LINE_WORDS * 4);
    localparam int TO_W   = log2_ceil(TIMEOUT + 1);
    localparam logic [SA_W-1:0] ADDR_MASK = ~SA_W'((1 << OFF_W) - 1);

    state_t            state, state_nxt;
    logic [LINE_W-1:0] line_q;
    logic [SA_W-1:0]   addr_q;
    logic [HW_W-1:0]   hw_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              all_rcvd;
    logic              err_q;
    logic [AW-1:0]     buf_addr_q;
    logic [31:0]       pack_word;
    logic              pack_valid;

    logic accept, dv_take, timeout_hit;

    // Requests are sampled whenever busy is low, which includes the ack cycle.
    assign accept      = bus.fill_req && (state == IDLE || state == DONE);
    assign dv_take     = (state == DATA) && bus.sd_dv && !all_rcvd;
    assign timeout_hit = (state == DATA) && !all_rcvd && !bus.sd_dv &&
                         (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ:  if (bus.sd_gnt) state_nxt = DATA;
            DATA: if (all_rcvd || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = accept ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.sd_req   = 1'b0;
        bus.fill_ack = 1'b0;
        bus.fill_err = 1'b0;
        unique case (state)
            REQ: begin
                bus.busy   = 1'b1;
                bus.sd_req = 1'b1;
            end
            DATA: bus.busy = 1'b1;
            DONE: begin
                bus.fill_ack = 1'b1;
                bus.fill_err = err_q;
            end
            default: ;
        endcase
    end

    // Timeout counter only advances in DATA and restarts on every halfword.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_q     <= '0;
            addr_q     <= '0;
            hw_cnt     <= '0;
            to_cnt     <= '0;
            all_rcvd   <= 1'b0;
            err_q      <= 1'b0;
            buf_addr_q <= '0;
        end else begin
            if (accept) begin
                line_q   <= bus.fill_line;
                addr_q   <= bus.fill_addr & ADDR_MASK;
                hw_cnt   <= '0;
                to_cnt   <= '0;
                all_rcvd <= 1'b0;
                err_q    <= 1'b0;
            end
            if (state == DATA) begin
                to_cnt <= bus.sd_dv ? '0 : to_cnt + TO_W'(1);
            end
            if (dv_take) begin
                hw_cnt <= hw_cnt + HW_W'(1);
                if (hw_cnt == HW_W'(HW_N - 1)) all_rcvd <= 1'b1;
                if (hw_cnt[0]) buf_addr_q <= {line_q, hw_cnt[HW_W-1:1]};
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    sdram_hw_packer u_packer (
        .clock (clock),
        .reset (reset),
        .start (accept),
        .take  (dv_take),
        .odd   (hw_cnt[0]),
        .dat   (bus.sd_dat),
        .word  (pack_word),
        .valid (pack_valid)
    );

    assign bus.sd_addr  = addr_q;
    assign bus.buf_we   = pack_valid;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_dat  = pack_word;

endmodule

// File: tb/tb_sdram_line_fill.sv
// Directed bench for sdram_line_fill: fills, gaps, timeout, dropped requests, reset, back-to-back.
module tb_sdram_line_fill;
    import sdram_fill_pkg::*;

    localparam int TIMEOUT = 64;

    logic clock;
    logic reset;

    sdram_line_fill_if #(.AW(8), .LINE_WORDS(LINE_WORDS_DEF), .SA_W(25)) bus ();

    sdram_line_fill #(.AW(8), .LINE_WORDS(LINE_WORDS_DEF), .SA_W(25), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cyc  = 0;

    logic [31:0] mem     [256] = '{default: 32'hDEAD_BEEF};
    int          wr_hits [256] = '{default: 0};
    int          we_cnt  = 0;
    int          ack_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Buffer model and pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.buf_we) begin
            mem[bus.buf_addr]     = bus.buf_dat;
            wr_hits[bus.buf_addr] = wr_hits[bus.buf_addr] + 1;
            we_cnt                = we_cnt + 1;
        end
        if (bus.fill_ack) ack_cnt = ack_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] base, input logic [15:0] step, input int k);
        logic [15:0] hi, lo;
        hi = 16'(base + 16'(2 * k) * step);
        lo = 16'(base + 16'(2 * k + 1) * step);
        return {hi, lo};
    endfunction

    // Request in the current cycle, grant the cycle after sd_req is seen; returns in the first DATA cycle.
    task automatic start_fill(input logic [5:0] line, input logic [24:0] addr);
        bus.fill_line = line;
        bus.fill_addr = addr;
        bus.fill_req  = 1'b1;
        req_cyc       = cyc;
        tick();
        bus.fill_req  = 1'b0;
        check("sd_req_rise", 32'(bus.sd_req), 1);
        check("busy_rise", 32'(bus.busy), 1);
        tick();
        bus.sd_gnt = 1'b1;
        tick();
        bus.sd_gnt = 1'b0;
        check("sd_req_fall", 32'(bus.sd_req), 0);
        check("sd_addr", 32'(bus.sd_addr), 32'({addr[24:4], 4'h0}));
    endtask

    task automatic burst(input int n, input int gap, input logic [15:0] base,
                         input logic [15:0] step, input bit chk_we);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) tick();
            end
            bus.sd_dv  = 1'b1;
            bus.sd_dat = 16'(base + 16'(i) * step);
            tick();
            bus.sd_dv  = 1'b0;
            bus.sd_dat = 16'hFFFF;
            if (chk_we) check("buf_we_timing", 32'(bus.buf_we), 32'(i % 2));
        end
    endtask

    task automatic wait_ack(input int max, output int waited);
        waited = 0;
        while (!bus.fill_ack && waited < max) begin
            tick();
            waited++;
        end
        check("ack_seen", 32'(bus.fill_ack), 1);
    endtask

    int waited;
    int we_base;
    int ack_base;
    int l5_hits;

    initial begin
        reset         = 1'b1;
        bus.fill_req  = 1'b0;
        bus.fill_line = '0;
        bus.fill_addr = '0;
        bus.sd_gnt    = 1'b0;
        bus.sd_dv     = 1'b0;
        bus.sd_dat    = 16'h0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ack", 32'(bus.fill_ack), 0);
        check("rst_err", 32'(bus.fill_err), 0);
        check("rst_sd_req", 32'(bus.sd_req), 0);
        check("rst_buf_we", 32'(bus.buf_we), 0);
        check("rst_sd_addr", 32'(bus.sd_addr), 0);
        check("rst_buf_addr", 32'(bus.buf_addr), 0);
        check("rst_buf_dat", bus.buf_dat, 0);
        reset = 1'b0;
        tick();

        // Basic fill, plus one stray halfword after the final one
        we_base = we_cnt;
        start_fill(6'd3, 25'h000_1234);
        check("basic_sd_addr", 32'(bus.sd_addr), 32'h000_1230);
        burst(8, 0, 16'h1111, 16'h1111, 1'b1);
        bus.sd_dv  = 1'b1;
        bus.sd_dat = 16'hEEEE;
        tick();
        bus.sd_dv  = 1'b0;
        check("basic_ack_cycle", 32'(bus.fill_ack), 1);
        wait_ack(4, waited);
        check("basic_latency", 32'(cyc - req_cyc), 12);
        check("basic_err", 32'(bus.fill_err), 0);
        check("basic_busy_at_ack", 32'(bus.busy), 0);
        tick();
        check("basic_w12", mem[12], 32'h1111_2222);
        check("basic_w13", mem[13], 32'h3333_4444);
        check("basic_w14", mem[14], 32'h5555_6666);
        check("basic_w15", mem[15], 32'h7777_8888);
        check("basic_we_count", 32'(we_cnt - we_base), 4);
        check("basic_hits_w15", 32'(wr_hits[15]), 1);

        // Gapped burst: five idle cycles between halfwords
        we_base = we_cnt;
        start_fill(6'd3, 25'h000_1234);
        burst(8, 5, 16'h1111, 16'h1111, 1'b1);
        wait_ack(10, waited);
        check("gap_ack_delay", 32'(waited + 1), 2);
        check("gap_err", 32'(bus.fill_err), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("gap_word", mem[12 + k], exp_word(16'h1111, 16'h1111, k));
            check("gap_rewritten", 32'(wr_hits[12 + k]), 2);
        end
        check("gap_we_count", 32'(we_cnt - we_base), 4);

        // Timeout after three halfwords
        we_base = we_cnt;
        start_fill(6'd1, 25'h000_0040);
        burst(3, 0, 16'hAAAA, 16'h1111, 1'b0);
        wait_ack(200, waited);
        check("to_idle_cycles", 32'(waited), TIMEOUT);
        check("to_err", 32'(bus.fill_err), 1);
        check("to_busy", 32'(bus.busy), 0);
        tick();
        check("to_we_count", 32'(we_cnt - we_base), 1);
        check("to_w4", mem[4], 32'hAAAA_BBBB);
        check("to_w5_untouched", 32'(wr_hits[5]), 0);

        // Request while busy is dropped
        ack_base = ack_cnt;
        start_fill(6'd2, 25'h000_0100);
        burst(3, 0, 16'h2000, 16'h0101, 1'b0);
        bus.fill_req  = 1'b1;
        bus.fill_line = 6'd5;
        bus.fill_addr = 25'h000_0999;
        tick();
        bus.fill_req  = 1'b0;
        check("busy_req_sd_addr", 32'(bus.sd_addr), 32'h000_0100);
        burst(5, 0, 16'(16'h2000 + 16'h0303), 16'h0101, 1'b0);
        wait_ack(10, waited);
        check("busy_req_err", 32'(bus.fill_err), 0);
        for (int i = 0; i < 20; i++) tick();
        check("busy_req_single_ack", 32'(ack_cnt - ack_base), 1);
        check("busy_req_no_sd_req", 32'(bus.sd_req), 0);
        l5_hits = 0;
        for (int k = 20; k < 24; k++) l5_hits += wr_hits[k];
        check("busy_req_no_line5", 32'(l5_hits), 0);
        for (int k = 0; k < 4; k++) check("busy_req_word", mem[8 + k], exp_word(16'h2000, 16'h0101, k));

        // Reset mid-burst
        start_fill(6'd6, 25'h000_0200);
        burst(4, 0, 16'h0101, 16'h0101, 1'b0);
        ack_base = ack_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_sd_req", 32'(bus.sd_req), 0);
        check("rst_mid_busy", 32'(bus.busy), 0);
        tick();
        tick();
        reset = 1'b0;
        burst(2, 0, 16'h7777, 16'h0001, 1'b0);
        tick();
        check("rst_mid_no_ack", 32'(ack_cnt - ack_base), 0);
        check("rst_mid_idle", 32'(bus.busy), 0);
        start_fill(6'd7, 25'h000_0300);
        burst(8, 0, 16'h3100, 16'h0022, 1'b0);
        wait_ack(10, waited);
        check("post_rst_err", 32'(bus.fill_err), 0);
        tick();
        for (int k = 0; k < 4; k++) check("post_rst_word", mem[28 + k], exp_word(16'h3100, 16'h0022, k));

        // Back-to-back: next request issued in the ack cycle
        start_fill(6'd4, 25'h000_0400);
        burst(8, 0, 16'h4000, 16'h0003, 1'b0);
        wait_ack(10, waited);
        check("b2b_first_err", 32'(bus.fill_err), 0);
        start_fill(6'd0, 25'h000_0500);
        burst(8, 0, 16'h9000, 16'h0011, 1'b0);
        wait_ack(10, waited);
        check("b2b_second_err", 32'(bus.fill_err), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("b2b_line4", mem[16 + k], exp_word(16'h4000, 16'h0003, k));
            check("b2b_line0", mem[k], exp_word(16'h9000, 16'h0011, k));
        end
        check("b2b_line_hw_total", 32'(LINE_HW), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
